vp_sequencer: RTL

- Controller that sequences one outstanding load-value speculation between the MEM stage, the register snapshot unit, the value predictor and the D-cache.
- It snapshots registers, obtains a prediction, releases it to the pipeline and verifies it against the real D-cache data.
- On mismatch or timeout it drives restore, flush and PC reload. It also generates the stall and flush overrides the hazard logic ORs into its per-stage controls.

---
 rtl/vp_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vp_sequencer.sv
// Load-value speculation sequencer. It tracks one outstanding speculation:
// register snapshot, prediction, early release, verification against D-cache
// data, and on mismatch or timeout the restore / flush / PC reload path.
module vp_sequencer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_is_read,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  snap_req,
  input  logic                  snap_done,
  output logic                  pred_en,
  output logic [ADDR_WIDTH-1:0] pred_pc,
  input  logic                  pred_valid,
  input  logic [DATA_WIDTH-1:0] pred_data,
  output logic                  spec_valid,
  output logic [DATA_WIDTH-1:0] spec_data,
  input  logic                  dc_valid,
  input  logic [DATA_WIDTH-1:0] dc_data,
  output logic                  train_valid,
  output logic [DATA_WIDTH-1:0] train_data,
  output logic                  restore_req,
  input  logic                  restore_done,
  output logic                  ov_stall,
  output logic                  ov_flush,
  output logic                  load_pc_we,
  output logic [ADDR_WIDTH-1:0] load_pc_target,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  stat_spec,
  output logic [CNT_WIDTH-1:0]  stat_mispred
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT) + 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSnap,
    StPred,
    StSpec,
    StRecover,
    StReload
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] spec_data_q;
  logic [DATA_WIDTH-1:0] train_data_q;
  logic                  spec_valid_q;
  logic                  train_valid_q;
  logic                  no_spec_q;
  logic [WaitW-1:0]      wait_q;
  logic [CNT_WIDTH-1:0]  stat_spec_q;
  logic [CNT_WIDTH-1:0]  stat_mispred_q;

  // Sequencer FSM with latched PC/data, wait counter and saturating stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      pc_q           <= '0;
      spec_data_q    <= '0;
      train_data_q   <= '0;
      spec_valid_q   <= 1'b0;
      train_valid_q  <= 1'b0;
      no_spec_q      <= 1'b0;
      wait_q         <= '0;
      stat_spec_q    <= '0;
      stat_mispred_q <= '0;
    end else begin
      spec_valid_q  <= 1'b0;
      train_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid && req_is_read) begin
            if (no_spec_q && (req_pc == pc_q)) begin
              // Re-execution of the recovered load goes through unspeculated.
              no_spec_q <= 1'b0;
            end else begin
              pc_q      <= req_pc;
              no_spec_q <= 1'b0;
              state_q   <= StSnap;
            end
          end
        end
        StSnap: begin
          if (snap_done) state_q <= StPred;
        end
        StPred: begin
          if (dc_valid) begin
            // Real data already here: no point speculating, just train.
            train_valid_q <= 1'b1;
            train_data_q  <= dc_data;
            state_q       <= StIdle;
          end else if (pred_valid) begin
            spec_data_q  <= pred_data;
            spec_valid_q <= 1'b1;
            wait_q       <= '0;
            if (!(&stat_spec_q)) stat_spec_q <= stat_spec_q + CNT_WIDTH'(1);
            state_q      <= StSpec;
          end
        end
        StSpec: begin
          if (dc_valid) begin
            train_valid_q <= 1'b1;
            train_data_q  <= dc_data;
            if (dc_data == spec_data_q) begin
              state_q <= StIdle;
            end else begin
              if (!(&stat_mispred_q)) stat_mispred_q <= stat_mispred_q + CNT_WIDTH'(1);
              state_q <= StRecover;
            end
          end else if (wait_q == WaitLast) begin
            if (!(&stat_mispred_q)) stat_mispred_q <= stat_mispred_q + CNT_WIDTH'(1);
            state_q <= StRecover;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StRecover: begin
          if (restore_done) state_q <= StReload;
        end
        StReload: begin
          no_spec_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore decodes; the SPEC-state stall follows req_valid combinationally.
  assign snap_req       = (state_q == StSnap);
  assign pred_en        = (state_q == StPred);
  assign restore_req    = (state_q == StRecover);
  assign ov_flush       = (state_q == StRecover);
  assign ov_stall       = (state_q == StRecover) || ((state_q == StSpec) && req_valid);
  assign load_pc_we     = (state_q == StReload);
  assign load_pc_target = pc_q;
  assign busy           = (state_q != StIdle);
  assign pred_pc        = pc_q;
  assign spec_valid     = spec_valid_q;
  assign spec_data      = spec_data_q;
  assign train_valid    = train_valid_q;
  assign train_data     = train_data_q;
  assign stat_spec      = stat_spec_q;
  assign stat_mispred   = stat_mispred_q;

endmodule
